// File: rtl/uart_rx.sv
// Oversampling-free UART receiver: 8N1 frames, mid-bit sampling with a programmable bit period of div+2 clk cycles.
// Define UART_RX_FILTER_EN to add a 3-tap majority glitch filter on the synchronized line.
module uart_rx #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [7:0]           data,
    output logic                 stb,
    output logic                 ferr
);

    // state   | meaning
    // S_IDLE  | line idle high, waiting for a falling edge
    // S_START | timing to the middle of the start bit
    // S_DATA  | sampling 8 data bits, LSB first
    // S_STOP  | timing to the middle of the stop bit
    // S_BREAK | stop bit was low, waiting for line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int TW = DIV_WIDTH + 1;

    state_t          state_q, state_d;
    logic            sync_q1, sync_q2;
    logic            line;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   half_load, full_load;
    logic            tc;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic            load_half, load_full, shift_en, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= rx;
            sync_q2 <= sync_q1;
        end
    end

`ifdef UART_RX_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync_q2};
        end
    end

    assign line = (sync_q2 & hist_q[0]) | (sync_q2 & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign line = sync_q2;
`endif

    // Timer value T puts the next sample T+1 cycles out: floor(P/2)-1 = div>>1, P-1 = div+1.
    assign half_load = TW'(div >> 1);
    assign full_load = TW'(div) + TW'(1);
    assign tc        = (timer_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!line) state_d = S_START;
            S_START: if (tc) state_d = line ? S_IDLE : S_DATA;
            S_DATA:  if (tc && (bit_cnt_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (tc) state_d = line ? S_IDLE : S_BREAK;
            S_BREAK: if (line) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE:  load_half = !line;
            S_START: load_full = tc && !line;
            S_DATA: begin
                load_full = tc;
                shift_en  = tc;
            end
            S_STOP:  capture = tc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            data      <= 8'h00;
            ferr      <= 1'b0;
            stb       <= 1'b0;
        end else begin
            if (load_half) begin
                timer_q <= half_load;
            end else if (load_full) begin
                timer_q <= full_load;
            end else if (!tc) begin
                timer_q <= timer_q - TW'(1);
            end

            // Counter wraps 7 -> 0 after the last bit, so it is ready for the next frame.
            if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shreg_q   <= {line, shreg_q[7:1]};
            end

            stb <= capture;
            if (capture) begin
                data <= shreg_q;
                ferr <= !line;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8: width of the bit-period divisor input.
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port div  input  DIV_WIDTH  bit period P = div+2 clk cycles, so div=28 at 30 MHz gives 1 MBaud.
REQ-006 SHALL have port data  output  8  last received byte.
REQ-007 SHALL have port stb  output  1  one-cycle pulse when data and ferr update.
REQ-008 SHALL have port ferr  output  1  framing error flag for the byte qualified by stb.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer reset to 1; all line decisions use the synchronized value, called "line" below.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: line=0 SHALL enter START and load the bit timer so the first sample occurs floor(P/2) cycles later.
REQ-012 After each sample point, SHALL reload the timer so the next sample occurs exactly P cycles later; the timer SHALL be DIV_WIDTH+1 bits wide with no overflow for any div.
REQ-013 START sample: line=1 SHALL be a false start; return to IDLE with no stb. line=0 SHALL enter DATA.
REQ-014 DATA: SHALL sample 8 bits LSB first into a shift register, with a 3-bit counter; after bit 7 enter STOP.
REQ-015 STOP sample: line=1 SHALL load data, pulse stb for 1 cycle with ferr=0, and enter IDLE the following cycle.
REQ-016 STOP sample: line=0 SHALL load data, pulse stb with ferr=1, and enter BREAK.
REQ-017 BREAK: SHALL remain until line=1, then go to IDLE; no stb while in BREAK.
REQ-018 data and ferr SHALL hold their values between stb pulses; there is no backpressure, and an unread byte is overwritten by the next one.
REQ-019 A start bit beginning immediately after the stop sample point, with no idle gap, SHALL be detected; back-to-back bytes SHALL not be lost.
REQ-020 div changes SHALL take effect at the next timer reload; behaviour is specified only for div >= 2.
REQ-021 stb SHALL assert on the cycle after the stop-bit sample point; stb latency from the rx stop-bit midpoint SHALL be fixed (synchronizer, plus filter if enabled).

Reset
REQ-022 While rst_n=0: state=IDLE, data=8'h00, stb=0, ferr=0, timer and bit counter cleared, synchronizer and filter flops set to 1.
REQ-023 Reset asserted mid-byte SHALL abort the byte without stb; after release, the next complete frame SHALL be received correctly.

Configuration
REQ-024 Macro UART_RX_FILTER_EN defined: line SHALL be the 3-tap majority of the last three synchronized samples, adding 1 cycle of latency; single-cycle glitches SHALL be rejected.
REQ-025 Macro UART_RX_FILTER_EN undefined: line SHALL be the synchronizer output directly; no filter flops are present.

Verification
REQ-026 div=28, frame 0x55 with stop=1 -> exactly one stb, data=8'h55, ferr=0.
REQ-027 div=28, frame 0xA3 with stop=0 and line held low 100 cycles -> one stb with data=8'hA3, ferr=1; no further stb until rx returns high; a following frame 0x3C is received with ferr=0.
REQ-028 div=28, rx low for 10 cycles then high -> no stb, FSM back in IDLE.
REQ-029 div=28, frames 0x00 then 0xFF back-to-back with no idle -> two stb pulses, data 8'h00 then 8'hFF, both ferr=0.
REQ-030 rst_n pulsed low during bit 4 of a frame -> outputs zero, no stb; next frame 0x81 is received as 8'h81.
REQ-031 With UART_RX_FILTER_EN, div=28, a 1-cycle inverted glitch mid-bit in frame 0x0F -> data=8'h0F; without the macro, a glitch placed on a sample point corrupts that bit.
